datapath_sequencer: RTL



---
 rtl/datapath_sequencer_pkg.sv | 48 ++++
 rtl/datapath_sequencer_seq_decode.sv | 57 +++++
 rtl/datapath_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer_pkg
// Description : Opcodes, FSM state codes and datapath select encodings shared
//               by the sequencer and the 8-bit register/ALU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_sequencer_pkg;

    typedef enum logic [2:0] {
        c_OP_LDI = 3'b000,
        c_OP_MOV = 3'b001,
        c_OP_XOR = 3'b010,
        c_OP_AND = 3'b011,
        c_OP_SHL = 3'b100,
        c_OP_XSH = 3'b101
    } opcode_e;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_LATCH = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    localparam logic [1:0] c_SR_IN  = 2'b00;
    localparam logic [1:0] c_SR_ALU = 2'b01;
    localparam logic [1:0] c_SR_TMP = 2'b10;

    localparam logic [2:0] c_TSEL_ALU = 3'b000;
    localparam logic [2:0] c_TSEL_R0  = 3'b001;
    localparam logic [2:0] c_TSEL_BIN = 3'b010;

    localparam logic [2:0] c_BSEL_R1 = 3'b000;
    localparam logic [2:0] c_BSEL_R2 = 3'b001;
    localparam logic [2:0] c_BSEL_R3 = 3'b010;

    localparam logic [1:0] c_ALU_XOR  = 2'b00;
    localparam logic [1:0] c_ALU_AND  = 2'b01;
    localparam logic [1:0] c_ALU_SHL  = 2'b10;
    localparam logic [1:0] c_ALU_PASS = 2'b11;

    // Every opcode except LDI reads a source register through Bin.
    function automatic logic op_uses_rs(input logic [2:0] op);
        return (op != c_OP_LDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_sequencer_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : seq_decode
// Description : Combinational opcode decode: phase count, per-phase tmp/ALU
//               selects, write-phase sr/aluop and illegal-opcode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_decode
    import datapath_sequencer_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_phase,
    output logic [1:0] o_num_phases,
    output logic [2:0] o_ph_tsel,
    output logic [1:0] o_ph_aluop,
    output logic [1:0] o_wr_sr,
    output logic [1:0] o_wr_aluop,
    output logic       o_illegal
);

    always_comb begin
        o_num_phases = 2'd0;
        o_ph_tsel    = c_TSEL_ALU;
        o_ph_aluop   = c_ALU_XOR;
        o_wr_sr      = c_SR_ALU;
        o_wr_aluop   = c_ALU_XOR;
        o_illegal    = 1'b0;
        case (i_op)
            c_OP_LDI: o_wr_sr = c_SR_IN;
            c_OP_MOV: o_wr_aluop = c_ALU_PASS;
            c_OP_XOR: begin
                o_num_phases = 2'd1;
                o_ph_tsel    = c_TSEL_R0;
            end
            c_OP_AND: begin
                o_num_phases = 2'd1;
                o_ph_tsel    = c_TSEL_R0;
                o_wr_aluop   = c_ALU_AND;
            end
            c_OP_SHL: begin
                o_num_phases = 2'd1;
                o_ph_tsel    = c_TSEL_BIN;
                o_wr_aluop   = c_ALU_SHL;
            end
            c_OP_XSH: begin
                // Phase 0 loads R0 into tmp, phase 1 folds in Rs via the ALU.
                o_num_phases = 2'd2;
                o_ph_tsel    = i_phase ? c_TSEL_ALU : c_TSEL_R0;
                o_ph_aluop   = c_ALU_XOR;
                o_wr_aluop   = c_ALU_SHL;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer
// Description : Accepts one instruction per valid/ready handshake and drives
//               the register/ALU datapath strobes phase by phase (Moore).
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int LT_SETUP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs,
    input  logic [7:0] instr_imm,
    output logic [7:0] dp_in,
    output logic [1:0] dp_sr,
    output logic [1:0] dp_Rn,
    output logic       dp_w,
    output logic [1:0] dp_aluop,
    output logic       dp_lt,
    output logic [2:0] dp_tsel,
    output logic [2:0] dp_bsel,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] c_CNT_LOAD = 2'(LT_SETUP - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [2:0] r_op;
    logic [1:0] r_rd;
    logic [1:0] r_rs;
    logic [7:0] r_imm;
    logic       r_phase;
    logic [1:0] r_cnt;
    logic [1:0] r_sr;
    logic [1:0] r_rn;

    logic [2:0] w_dec_op;
    logic       w_dec_phase;
    logic [1:0] w_num_phases;
    logic [2:0] w_ph_tsel;
    logic [1:0] w_ph_aluop;
    logic [1:0] w_wr_sr;
    logic [1:0] w_wr_aluop;
    logic       w_illegal;
    logic       w_in_phase;

    // In IDLE the decoder looks at the offered opcode to pick the first state.
    assign w_dec_op    = (r_state == c_ST_IDLE) ? instr_op : r_op;
    assign w_dec_phase = (r_state == c_ST_IDLE) ? 1'b0 : r_phase;

    seq_decode u_seq_decode (
        .i_op         (w_dec_op),
        .i_phase      (w_dec_phase),
        .o_num_phases (w_num_phases),
        .o_ph_tsel    (w_ph_tsel),
        .o_ph_aluop   (w_ph_aluop),
        .o_wr_sr      (w_wr_sr),
        .o_wr_aluop   (w_wr_aluop),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (instr_valid) begin
                    if (w_illegal || (op_uses_rs(instr_op) && (instr_rs == 2'd0)))
                        w_state_nxt = c_ST_ERR;
                    else if (w_num_phases == 2'd0)
                        w_state_nxt = c_ST_WRITE;
                    else
                        w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: if (r_cnt == 2'd0) w_state_nxt = c_ST_LATCH;
            c_ST_LATCH: begin
                if (({1'b0, r_phase} + 2'd1) < w_num_phases) w_state_nxt = c_ST_SETUP;
                else                                        w_state_nxt = c_ST_WRITE;
            end
            c_ST_WRITE: w_state_nxt = c_ST_IDLE;
            c_ST_ERR:   w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 3'd0;
            r_rd    <= 2'd0;
            r_rs    <= 2'd0;
            r_imm   <= 8'd0;
            r_phase <= 1'b0;
            r_cnt   <= 2'd0;
            r_sr    <= c_SR_IN;
            r_rn    <= 2'd0;
        end else begin
            if ((r_state == c_ST_IDLE) && instr_valid) begin
                r_op    <= instr_op;
                r_rd    <= instr_rd;
                r_rs    <= instr_rs;
                r_imm   <= instr_imm;
                r_phase <= 1'b0;
                r_cnt   <= c_CNT_LOAD;
            end
            if ((r_state == c_ST_SETUP) && (r_cnt != 2'd0))
                r_cnt <= r_cnt - 2'd1;
            if ((r_state == c_ST_LATCH) && (w_state_nxt == c_ST_SETUP)) begin
                r_phase <= r_phase + 1'b1;
                r_cnt   <= c_CNT_LOAD;
            end
            // sr and Rn are captured on entry to WRITE and held afterwards.
            if ((w_state_nxt == c_ST_WRITE) && (r_state != c_ST_WRITE)) begin
                r_sr <= w_wr_sr;
                r_rn <= (r_state == c_ST_IDLE) ? instr_rd : r_rd;
            end
        end
    end

    assign w_in_phase  = (r_state == c_ST_SETUP) || (r_state == c_ST_LATCH);

    assign instr_ready = (r_state == c_ST_IDLE);
    assign dp_in       = r_imm;
    assign dp_sr       = r_sr;
    assign dp_Rn       = r_rn;
    assign dp_w        = (r_state == c_ST_WRITE);
    assign dp_lt       = (r_state == c_ST_LATCH);
    assign done        = (r_state == c_ST_WRITE);
    assign err         = (r_state == c_ST_ERR);
    assign dp_tsel     = w_in_phase ? w_ph_tsel : c_TSEL_ALU;
    assign dp_aluop    = w_in_phase ? w_ph_aluop :
                         (r_state == c_ST_WRITE) ? w_wr_aluop : c_ALU_XOR;

    always_comb begin
        case (r_rs)
            2'd2:    dp_bsel = c_BSEL_R2;
            2'd3:    dp_bsel = c_BSEL_R3;
            default: dp_bsel = c_BSEL_R1;
        endcase
    end

endmodule
`default_nettype wire
